cpu_ram_2p: RTL and testbench

Parametrised successor to the single-port CPU RAM. One shared synchronous memory array serves two independent native CPU memory ports (valid/ready/addr/wdata/wstrb/rdata), e.g. instruction fetch on port A and data on port B. The block adds round-robin arbitration between the ports and a configurable response latency. Data width and depth are generic, and byte-strobe writes are kept. It sits between the CPU (or CPU plus DMA) and the bus decoder as the main on-chip RAM.

---
 rtl/cpu_ram_2p.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_ram_2p.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ram_2p.sv
// Dual-port CPU RAM: two native valid/ready ports share one synchronous array
// through round-robin arbitration, with a configurable response latency.

module cpu_ram_2p_port #(
    parameter int unsigned AW      = 15,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NB      = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NB-1:0]    wstrb,
    input  logic             gnt,
    input  logic [WIDTH-1:0] arr_word,
    output logic             cand_c,
    output logic [AW-1:0]    req_addr_c,
    output logic [WIDTH-1:0] req_wdata_c,
    output logic [NB-1:0]    req_wstrb_c,
    output logic [WIDTH-1:0] rdata,
    output logic             ready
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, PEND, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    cap_addr_q, cap_addr_d;
    logic [WIDTH-1:0] cap_wdata_q, cap_wdata_d;
    logic [NB-1:0]    cap_wstrb_q, cap_wstrb_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic             go_done, done_read;
    logic [WIDTH-1:0] done_data;

    // Next-state, capture and completion logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_wstrb_d = cap_wstrb_q;
        hold_d      = hold_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        go_done     = 1'b0;
        done_read   = 1'b0;
        done_data   = hold_q;

        cand_c      = ((state_q == IDLE) && valid) || (state_q == PEND);
        req_addr_c  = (state_q == IDLE) ? addr  : cap_addr_q;
        req_wdata_c = (state_q == IDLE) ? wdata : cap_wdata_q;
        req_wstrb_c = (state_q == IDLE) ? wstrb : cap_wstrb_q;

        case (state_q)
            IDLE, PEND: begin
                if ((state_q == IDLE) && valid) begin
                    cap_addr_d  = addr;
                    cap_wdata_d = wdata;
                    cap_wstrb_d = wstrb;
                end
                if (cand_c) begin
                    if (gnt) begin
                        hold_d = arr_word;
                        // Single-cycle latency completes straight from the grant edge
                        if (LATENCY == 1) begin
                            state_d   = DONE;
                            go_done   = 1'b1;
                            done_read = (req_wstrb_c == '0);
                            done_data = arr_word;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CW'(LATENCY - 1)) begin
                    state_d   = DONE;
                    go_done   = 1'b1;
                    done_read = (cap_wstrb_q == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go_done) begin
            ready_d = 1'b1;
            if (done_read) rdata_d = done_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_wstrb_q <= '0;
            hold_q      <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_wstrb_q <= cap_wstrb_d;
            hold_q      <= hold_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;

endmodule

module cpu_ram_2p #(
    parameter  int unsigned SIZE    = 13,
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned LATENCY = 1,
    localparam int unsigned NB      = WIDTH / 8,
    localparam int unsigned AW      = SIZE + $clog2(NB)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    input  logic [NB-1:0]    a_wstrb,
    output logic [WIDTH-1:0] a_rdata,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    input  logic [NB-1:0]    b_wstrb,
    output logic [WIDTH-1:0] b_rdata,
    output logic             b_ready
);

    localparam int unsigned OFF   = $clog2(NB);
    localparam int unsigned DEPTH = 1 << SIZE;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             a_cand, b_cand, gnt_a, gnt_b, last_b;
    logic [AW-1:0]    a_req_addr, b_req_addr;
    logic [WIDTH-1:0] a_req_wdata, b_req_wdata, sel_wdata, arr_word;
    logic [NB-1:0]    a_req_wstrb, b_req_wstrb, sel_wstrb;
    logic [SIZE-1:0]  idx;

    cpu_ram_2p_port #(.AW(AW), .WIDTH(WIDTH), .NB(NB), .LATENCY(LATENCY)) u_port_a (
        .clk(clk), .reset(reset), .valid(a_valid), .addr(a_addr), .wdata(a_wdata),
        .wstrb(a_wstrb), .gnt(gnt_a), .arr_word(arr_word), .cand_c(a_cand),
        .req_addr_c(a_req_addr), .req_wdata_c(a_req_wdata), .req_wstrb_c(a_req_wstrb),
        .rdata(a_rdata), .ready(a_ready)
    );

    cpu_ram_2p_port #(.AW(AW), .WIDTH(WIDTH), .NB(NB), .LATENCY(LATENCY)) u_port_b (
        .clk(clk), .reset(reset), .valid(b_valid), .addr(b_addr), .wdata(b_wdata),
        .wstrb(b_wstrb), .gnt(gnt_b), .arr_word(arr_word), .cand_c(b_cand),
        .req_addr_c(b_req_addr), .req_wdata_c(b_req_wdata), .req_wstrb_c(b_req_wstrb),
        .rdata(b_rdata), .ready(b_ready)
    );

    // Round-robin grant: on a tie the port not granted last wins
    always_comb begin
        gnt_a     = a_cand && (!b_cand || last_b);
        gnt_b     = b_cand && !gnt_a;
        idx       = gnt_a ? SIZE'(a_req_addr >> OFF) : SIZE'(b_req_addr >> OFF);
        sel_wdata = gnt_a ? a_req_wdata : b_req_wdata;
        sel_wstrb = gnt_a ? a_req_wstrb : b_req_wstrb;
        arr_word  = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_b <= 1'b1;
        end else if (gnt_a || gnt_b) begin
            last_b <= gnt_b;
        end
    end

    // Array contents survive reset; byte lanes written under strobe
    always_ff @(posedge clk) begin
        if (reset && (gnt_a || gnt_b)) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (sel_wstrb[i]) mem[idx][i*8 +: 8] <= sel_wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_cpu_ram_2p.sv
// Directed bench for cpu_ram_2p: default config plus a 64-bit, latency-3 instance.

module tb_cpu_ram_2p;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [14:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic [3:0]  a_wstrb = '0, b_wstrb = '0;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, b_ready;

    logic        c_valid = 1'b0, d_valid = 1'b0;
    logic [10:0] c_addr = '0, d_addr = '0;
    logic [63:0] c_wdata = '0, d_wdata = '0;
    logic [7:0]  c_wstrb = '0, d_wstrb = '0;
    logic [63:0] c_rdata, d_rdata;
    logic        c_ready, d_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_ram_2p u_dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
        .a_rdata(a_rdata), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
        .b_rdata(b_rdata), .b_ready(b_ready)
    );

    cpu_ram_2p #(.SIZE(8), .WIDTH(64), .LATENCY(3)) u_dut64 (
        .clk(clk), .reset(reset),
        .a_valid(c_valid), .a_addr(c_addr), .a_wdata(c_wdata), .a_wstrb(c_wstrb),
        .a_rdata(c_rdata), .a_ready(c_ready),
        .b_valid(d_valid), .b_addr(d_addr), .b_wdata(d_wdata), .b_wstrb(d_wstrb),
        .b_rdata(d_rdata), .b_ready(d_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // One-cycle valid pulse on the 32-bit instance; returns rdata and latency (0 = timeout)
    task automatic acc1(input bit pb, input logic [14:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output int lat);
        bit seen = 1'b0;
        if (pb) begin b_valid = 1'b1; b_addr = addr; b_wdata = wd; b_wstrb = ws; end
        else    begin a_valid = 1'b1; a_addr = addr; a_wdata = wd; a_wstrb = ws; end
        lat = 0;
        rd  = 'x;
        for (int i = 1; i <= 8 && !seen; i++) begin
            step();
            a_valid = 1'b0;
            b_valid = 1'b0;
            if ((pb ? b_ready : a_ready) === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                rd   = pb ? b_rdata : a_rdata;
            end
        end
        step();
    endtask

    // Valid held until ready on the 64-bit instance; counts extra ready pulses afterwards
    task automatic hold2(input logic [10:0] addr, input logic [63:0] wd, input logic [7:0] ws,
                         output logic [63:0] rd, output int lat, output int extra);
        bit seen = 1'b0;
        c_valid = 1'b1; c_addr = addr; c_wdata = wd; c_wstrb = ws;
        lat   = 0;
        extra = 0;
        rd    = 'x;
        for (int i = 1; i <= 10 && !seen; i++) begin
            step();
            if (c_ready === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                rd   = c_rdata;
            end
        end
        c_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (c_ready !== 1'b0) extra++;
        end
    endtask

    logic [31:0] rd32;
    logic [63:0] rd64;
    logic [31:0] model [16];
    logic [31:0] lcg;
    int          lat, extra, nb;

    initial begin
        // Reset values
        step();
        step();
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd0);
        chk("rst_a_rdata", 64'(a_rdata), 64'd0);
        chk("rst_b_rdata", 64'(b_rdata), 64'd0);
        chk("rst_c_ready", 64'(c_ready), 64'd0);
        reset = 1'b1;

        // Word write on A, read back on B
        acc1(1'b0, 15'h10, 32'hDEADBEEF, 4'hF, rd32, lat);
        chk("wr_lat", 64'(lat), 64'd1);
        acc1(1'b1, 15'h10, 32'h0, 4'h0, rd32, lat);
        chk("rd_lat", 64'(lat), 64'd1);
        chk("rd_data", 64'(rd32), 64'hDEADBEEF);

        // Byte strobes, 32-bit
        acc1(1'b0, 15'h20, 32'h11223344, 4'hF, rd32, lat);
        acc1(1'b0, 15'h20, 32'hAABBCCDD, 4'h5, rd32, lat);
        acc1(1'b0, 15'h20, 32'h0, 4'h0, rd32, lat);
        chk("strb32", 64'(rd32), 64'h11BB33DD);
        chk("wr_keeps_rdata", 64'(a_rdata), 64'h11BB33DD);

        // Tie after reset: A wins, B reads the new data one cycle later
        do_reset();
        a_valid = 1'b1; a_addr = 15'h40; a_wdata = 32'h5; a_wstrb = 4'hF;
        b_valid = 1'b1; b_addr = 15'h40; b_wdata = 32'h0; b_wstrb = 4'h0;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("tie1_c1_a_ready", 64'(a_ready), 64'd1);
        chk("tie1_c1_b_ready", 64'(b_ready), 64'd0);
        step();
        chk("tie1_c2_a_ready", 64'(a_ready), 64'd0);
        chk("tie1_c2_b_ready", 64'(b_ready), 64'd1);
        chk("tie1_b_rdata", 64'(b_rdata), 64'h5);
        step();

        // A alone, then a tie: B was not granted last, so B reads old data first
        acc1(1'b0, 15'h40, 32'h0, 4'h0, rd32, lat);
        chk("tie_prep_rd", 64'(rd32), 64'h5);
        a_valid = 1'b1; a_addr = 15'h40; a_wdata = 32'h7; a_wstrb = 4'hF;
        b_valid = 1'b1; b_addr = 15'h40; b_wdata = 32'h0; b_wstrb = 4'h0;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("tie2_c1_b_ready", 64'(b_ready), 64'd1);
        chk("tie2_c1_a_ready", 64'(a_ready), 64'd0);
        chk("tie2_b_old_data", 64'(b_rdata), 64'h5);
        step();
        chk("tie2_c2_a_ready", 64'(a_ready), 64'd1);
        step();

        // Reset mid-operation: B pending behind A's granted write
        acc1(1'b1, 15'h10, 32'h0, 4'h0, rd32, lat);
        chk("pre_rst_rd", 64'(rd32), 64'hDEADBEEF);
        a_valid = 1'b1; a_addr = 15'h80; a_wdata = 32'h12345678; a_wstrb = 4'hF;
        b_valid = 1'b1; b_addr = 15'h84; b_wdata = 32'h0; b_wstrb = 4'h0;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("mid_a_ready", 64'(a_ready), 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
        chk("mid_rst_a_rdata", 64'(a_rdata), 64'd0);
        chk("mid_rst_b_rdata", 64'(b_rdata), 64'd0);
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            if (b_ready !== 1'b0) nb++;
            step();
        end
        chk("mid_no_b_ready", 64'(nb), 64'd0);
        acc1(1'b0, 15'h80, 32'h0, 4'h0, rd32, lat);
        chk("mid_write_kept", 64'(rd32), 64'h12345678);
        acc1(1'b1, 15'h40, 32'h0, 4'h0, rd32, lat);
        chk("mem_after_rst", 64'(rd32), 64'h7);

        // 64-bit, latency 3, valid held until ready
        hold2(11'h08, 64'h0123456789ABCDEF, 8'hFF, rd64, lat, extra);
        chk("l3_wr_lat", 64'(lat), 64'd3);
        chk("l3_wr_no_second", 64'(extra), 64'd0);
        hold2(11'h08, 64'hAABBCCDDEEFF0011, 8'h55, rd64, lat, extra);
        hold2(11'h08, 64'h0, 8'h00, rd64, lat, extra);
        chk("l3_rd_lat", 64'(lat), 64'd3);
        chk("l3_rd_no_second", 64'(extra), 64'd0);
        chk("strb64", rd64, 64'h01BB45DD89FFCD11);

        // LCG-driven single accesses against a reference model
        lcg = 32'd12345;
        for (int w = 0; w < 16; w++) begin
            lcg = lcg * 32'd1103515245 + 32'd12345;
            model[w] = lcg;
            acc1(w[0], 15'(32'h400 + 32'(w) * 4), lcg, 4'hF, rd32, lat);
        end
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] r, wd;
            logic [3:0]  ws, widx;
            lcg = lcg * 32'd1103515245 + 32'd12345;
            r   = lcg;
            lcg = lcg * 32'd1103515245 + 32'd12345;
            wd  = lcg;
            widx = r[23:20];
            ws   = r[16] ? r[27:24] : 4'h0;
            acc1(r[29], 15'(32'h400 + 32'(widx) * 4), wd, ws, rd32, lat);
            chk("rnd_lat", 64'(lat), 64'd1);
            if (ws == 4'h0) begin
                chk("rnd_rdata", 64'(rd32), 64'(model[widx]));
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) model[widx][b*8 +: 8] = wd[b*8 +: 8];
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
